// File: rtl/fetch_stage.sv
// Skylark-V instruction-fetch stage: owns the PC, drives instruction memory and
// holds the IF/ID pipeline register, applying redirects, stalls, flushes and memory waits.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic [31:0] ImemAddr,
    input  logic [31:0] ImemRdata,
    input  logic        ImemReady,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic [31:0] FetchCount
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcd_q, pcd_d;
    logic [31:0] pcplus4d_q, pcplus4d_d;
    logic        valid_q, valid_d;
    logic [31:0] count_q, count_d;
    logic [31:0] pc_plus_f;
    logic        capture;
    logic        advance;

    always_comb begin
        pc_plus_f = pc_q + 32'd4;
        capture   = !FlushD && !PCSrcE && !StallD && ImemReady;
        // The PC only moves past a word once decode has actually taken it.
        advance   = capture && !StallF;

        pc_d = pc_q;
        if (PCSrcE) begin
            pc_d = {PCTargetE[31:2], 2'b00};
        end else if (advance) begin
            pc_d = pc_plus_f;
        end

        instr_d    = instr_q;
        pcd_d      = pcd_q;
        pcplus4d_d = pcplus4d_q;
        valid_d    = valid_q;
        if (FlushD || PCSrcE || (!StallD && !ImemReady)) begin
            instr_d    = NOP_INSTR;
            pcd_d      = 32'd0;
            pcplus4d_d = 32'd0;
            valid_d    = 1'b0;
        end else if (capture) begin
            instr_d    = ImemRdata;
            pcd_d      = pc_q;
            pcplus4d_d = pc_plus_f;
            valid_d    = 1'b1;
        end

        count_d = capture ? count_q + 32'd1 : count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            pcd_q      <= 32'd0;
            pcplus4d_q <= 32'd0;
            valid_q    <= 1'b0;
            count_q    <= 32'd0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pcd_q      <= pcd_d;
            pcplus4d_q <= pcplus4d_d;
            valid_q    <= valid_d;
            count_q    <= count_d;
        end
    end

    assign ImemAddr   = pc_q;
    assign PCF        = pc_q;
    assign InstrD     = instr_q;
    assign PCD        = pcd_q;
    assign PCPlus4D   = pcplus4d_q;
    assign ValidD     = valid_q;
    assign FetchCount = count_q;

endmodule
